// File: rtl/rv_pkg.sv
// Shared RV32I encoder definitions: instruction format codes, error codes,
// base opcodes and the signed-immediate range helper.
package rv_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_BAD6 = 3'd6,
    FMT_BAD7 = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_RANGE    = 2'd1,
    ERR_MISALIGN = 2'd2,
    ERR_FMT      = 2'd3
  } err_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  // True when v is representable as a two's-complement value of 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (bits - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; flush wins over push and pop.
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: packs field-level requests into
// 32-bit words, range-checks the immediate and queues {err, instr}.
module instr_encoder
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_fmt,
  input  logic [6:0]       req_opcode,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [2:0]       req_funct3,
  input  logic [6:0]       req_funct7,
  input  logic [31:0]      req_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  fmt_e        fmt;
  logic [31:0] word;
  err_e        err;
  logic        accept;
  logic        fifo_full;
  logic        fifo_empty;
  logic [33:0] fifo_dout;

  assign fmt       = fmt_e'(req_fmt);
  assign req_ready = !fifo_full && !flush;
  assign accept    = req_valid && req_ready;

  // The word is always built from the truncated immediate; err only flags it.
  always_comb begin
    word = '0;
    err  = ERR_OK;
    case (fmt)
      FMT_R: word = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, req_opcode};
      FMT_I: begin
        word = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
        if (!fits_signed(req_imm, 12)) err = ERR_RANGE;
      end
      FMT_S: begin
        word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], req_opcode};
        if (!fits_signed(req_imm, 12)) err = ERR_RANGE;
      end
      FMT_B: begin
        word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                req_imm[4:1], req_imm[11], req_opcode};
        if (req_imm[0])                   err = ERR_MISALIGN;
        else if (!fits_signed(req_imm, 13)) err = ERR_RANGE;
      end
      FMT_U: begin
        word = {req_imm[31:12], req_rd, req_opcode};
        if (req_imm[11:0] != '0) err = ERR_RANGE;
      end
      FMT_J: begin
        word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, req_opcode};
        if (req_imm[0])                   err = ERR_MISALIGN;
        else if (!fits_signed(req_imm, 21)) err = ERR_RANGE;
      end
      default: begin
        word = '0;
        err  = ERR_FMT;
      end
    endcase
  end

  sync_fifo #(
    .WIDTH(34),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (flush),
    .push   (accept),
    .pop    (out_ready),
    .din    ({err, word}),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_instr = fifo_dout[31:0];
  assign out_err   = fifo_dout[33:32];

  // enc_count wraps; err_count sticks at all-ones. Flush leaves both alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (accept) begin
      enc_count <= enc_count + CNT_W'(1);
      if (err != ERR_OK && err_count != '1) err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: accepted requests queue their expected
// {err, instr}; a monitor pops and compares whenever the FIFO head is taken.
module tb_instr_encoder;
  import rv_pkg::*;

  typedef struct packed {
    logic [1:0]  err;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_fmt = '0;
  logic [6:0]  req_opcode = '0;
  logic [4:0]  req_rd = '0;
  logic [4:0]  req_rs1 = '0;
  logic [4:0]  req_rs2 = '0;
  logic [2:0]  req_funct3 = '0;
  logic [6:0]  req_funct7 = '0;
  logic [31:0] req_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [1:0]  out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  exp_t        sb[$];
  exp_t        exp_cur = '0;
  exp_t        mon_e;
  bit          mon_en = 1'b1;
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_enc = '0;
  logic [15:0] exp_errc = '0;

  instr_encoder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_fmt   (req_fmt),
    .req_opcode(req_opcode),
    .req_rd    (req_rd),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_funct3(req_funct3),
    .req_funct7(req_funct7),
    .req_imm   (req_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Acceptor: records the expected result of every handshake seen by the DUT.
  always @(negedge clk) begin
    if (mon_en && reset_n && req_valid && req_ready) begin
      sb.push_back(exp_cur);
      exp_enc++;
      if (exp_cur.err != 2'd0 && exp_errc != 16'hFFFF) exp_errc++;
    end
  end

  // Monitor: a flush discards everything queued; otherwise compare each pop.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (flush) begin
        sb.delete();
      end else if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_output: got %0h, expected no output", out_instr);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("out_instr", out_instr, mon_e.instr);
          checkOutput("out_err", 32'(out_err), 32'(mon_e.err));
        end
      end
    end
  end

  task automatic setReq(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] w, input logic [1:0] er);
    req_fmt    = fmt;
    req_opcode = op;
    req_rd     = rd;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_funct3 = f3;
    req_funct7 = f7;
    req_imm    = imm;
    exp_cur    = {er, w};
    req_valid  = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic applyStimulus(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm,
                               input logic [31:0] w, input logic [1:0] er);
    bit acc;
    acc = 1'b0;
    setReq(fmt, op, rd, rs1, rs2, f3, f7, imm, w, er);
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got no handshake, expected one within 20 cycles");
    end
  endtask

  task automatic pushU(input int k);
    applyStimulus(3'd4, OP_LUI, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k) << 12,
                  (32'(k) << 12) | (32'(k) << 7) | 32'h37, 2'd0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 30 && (sb.size() != 0 || out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_instr", out_instr, 32'd0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);
    checkOutput("rst_enc_count", 32'(enc_count), 32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Directed encodings with hand-computed words.
    applyStimulus(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 2'd0);
    checkOutput("latency_valid", 32'(out_valid), 32'd1);
    applyStimulus(3'd3, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0000_0463, 2'd0);
    applyStimulus(3'd3, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h0000_0363, 2'd2);
    applyStimulus(3'd5, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0010_00EF, 2'd0);
    applyStimulus(3'd4, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 2'd0);
    applyStimulus(3'd4, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h1234_52B7, 2'd1);
    applyStimulus(3'd7, OP_REG, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'h0000_1234, 32'h0000_0000, 2'd3);
    applyStimulus(3'd0, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEAD_BEEF, 32'h0020_81B3, 2'd0);
    applyStimulus(3'd0, OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0000_0000, 32'h4020_81B3, 2'd0);
    applyStimulus(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0093, 2'd1);
    applyStimulus(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0093, 2'd0);
    applyStimulus(3'd2, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC, 32'hFE20_AE23, 2'd0);
    applyStimulus(3'd3, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094, 32'h7E00_0FE3, 2'd0);
    applyStimulus(3'd3, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 32'h8000_0063, 2'd1);
    applyStimulus(3'd5, OP_JAL, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000F_FFFE, 32'h7FFF_F06F, 2'd0);
    applyStimulus(3'd5, OP_JAL, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h8000_006F, 2'd1);
    applyStimulus(3'd5, OP_JAL, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0001, 32'h8000_006F, 2'd2);
    drain();
    checkOutput("enc_count_directed", 32'(enc_count), 32'd17);
    checkOutput("err_count_directed", 32'(err_count), 32'd7);

    // Fill, pop-while-full, then simultaneous push and pop.
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) pushU(k);
    checkOutput("full_ready_low", 32'(req_ready), 32'd0);
    setReq(3'd4, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h5000, 32'h0000_52B7, 2'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("pop_frees_slot", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    out_ready = 1'b0;
    checkOutput("push_pop_steady_ready", 32'(req_ready), 32'd1);
    checkOutput("push_pop_steady_valid", 32'(out_valid), 32'd1);
    pushU(6);
    checkOutput("refill_full", 32'(req_ready), 32'd0);
    drain();

    // Flush with three entries queued and a request presented.
    out_ready = 1'b0;
    for (int k = 7; k <= 9; k++) pushU(k);
    setReq(3'd4, OP_LUI, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'hA000, 32'h0000_A537, 2'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("flush_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    req_valid = 1'b0;
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_enc_count", 32'(enc_count), 32'(exp_enc));
    pushU(11);
    drain();
    checkOutput("model_enc_count", 32'(enc_count), 32'(exp_enc));
    checkOutput("model_err_count", 32'(err_count), 32'(exp_errc));

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    pushU(12);
    pushU(13);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_enc", 32'(enc_count), 32'd0);
    checkOutput("async_rst_err", 32'(err_count), 32'd0);
    sb.delete();
    exp_enc = '0;
    exp_errc = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Back-to-back bad-format requests: err_count saturates, enc_count wraps.
    mon_en = 1'b0;
    out_ready = 1'b1;
    setReq(3'd6, OP_REG, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'd0, 2'd3);
    repeat (65535) @(posedge clk);
    #1;
    checkOutput("sat_err_ffff", 32'(err_count), 32'h0000_FFFF);
    checkOutput("sat_enc_ffff", 32'(enc_count), 32'h0000_FFFF);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("sat_err_hold", 32'(err_count), 32'h0000_FFFF);
    checkOutput("wrap_enc", 32'(enc_count), 32'h0000_0001);
    req_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("final_out_valid", 32'(out_valid), 32'd0);
    mon_en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
